data_memory_lsu: RTL and testbench
==================================

// Module: data_memory_lsu
// PURPOSE
//  Byte-addressed RV32I data memory with sized, sign/zero-extending loads and
//  byte-enabled stores (LB/LH/LW/LBU/LHU, SB/SH/SW). Successor to the flat
//  word-addressed data RAM: the depth is parametrised and the read port is
//  registered, with a per-request done/error pulse. Sits in the MEM stage and
//  takes funct3 straight from the decoder.
// PARAMETERS
//  ADDR_W   12   byte-address width; depth = 2**(ADDR_W-2) 32-bit words
//  ZERO_ERR 1    1: o_Dataread forced to 0 on an errored load; 0: holds previous value
// PORTS
//  i_clk         in   1       rising-edge clock; single clock domain
//  i_rst         in   1       reset, synchronous, active-high
//  i_req         in   1       request valid; one request is accepted per cycle
//  i_wrenb       in   1       1 = store, 0 = load (sampled when i_req = 1)
//  i_funct3      in   3       access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_Address     in   ADDR_W  byte address
//  i_Datawrite   in   32      store data; the size is taken from its LSBs
//  o_done        out  1       1-cycle pulse, one cycle after each accepted request
//  o_err         out  1       valid only with o_done; misaligned access or illegal funct3
//  o_Dataread    out  32      load result, valid with o_done when the request was a load
//  o_err_sticky  out  1       set by any error; cleared only by i_rst
// BEHAVIOUR
//  - Reset values (sync, i_rst = 1 at a clock edge): o_done = 0, o_err = 0,
//    o_Dataread = 0, o_err_sticky = 0. RAM contents are NOT reset.
//  - No back-pressure; there is no ready signal. Latency is exactly 1:
//    a request at edge N raises o_done for cycle N..N+1.
//  - Word index = i_Address[ADDR_W-1:2]; byte lane = i_Address[1:0].
//  - Alignment:
//    - H/HU require addr[0] = 0.
//    - W requires addr[1:0] = 00.
//    - funct3 of 011, 110 or 111 is illegal; a store with 100 or 101 is illegal.
//  - Error request: no RAM write; o_done = 1 and o_err = 1 next cycle;
//    o_Dataread = 0 when ZERO_ERR = 1; o_err_sticky is set.
//  - Store: byte enables come from the size and lane.
//    - SB writes lane k from Datawrite[7:0].
//    - SH writes lanes {1,0} or {3,2} from Datawrite[15:0].
//    - SW writes all 4 lanes.
//    - Unselected bytes are preserved, with no read-modify-write cycle.
//    - The write commits at the accepting edge. o_Dataread holds its value
//      during a store's o_done.
//  - Load: the word is read at the accepting edge, then the lane is selected.
//    - B/H are sign-extended; BU/HU are zero-extended; W is passed unchanged.
//    - The result is registered into o_Dataread.
//  - Store at edge N followed by a load of the same word at edge N+1: the
//    load returns the new data. There is no same-cycle read/write hazard,
//    because there is one port and one request per cycle.
//  - i_req = 0: the RAM is unchanged; o_done = 0 on the next cycle; o_Dataread holds.
//  - Reset mid-operation: if i_rst = 1 at edge N+1, the o_done of a request
//    accepted at N is suppressed (o_done = 0). A store accepted at N has
//    already committed.
//  - i_rst has priority over i_req in the same cycle: the request is dropped
//    and no write occurs.
//  - Address wrap: none; every ADDR_W-bit address maps to a valid word.
// TESTING
//  1. SW 0xDEADBEEF @0x010, then LW @0x010 -> o_done, o_err = 0, o_Dataread = 0xDEADBEEF.
//  2. SB 0x0000007F @0x011, LW @0x010 -> 0xDEAD7FEF; LB @0x013 -> 0xFFFFFFDE;
//     LBU @0x013 -> 0x000000DE; LH @0x012 -> 0xFFFFDEAD; LHU @0x012 -> 0x0000DEAD.
//  3. SH 0x1234 @0x011 (misaligned) -> o_err = 1, o_err_sticky = 1;
//     LW @0x010 -> still 0xDEAD7FEF. LW @0x012 -> o_err = 1, o_Dataread = 0.
//  4. Back-to-back: SW 0xA5A5A5A5 @0x020 then LW @0x020 on the next cycle
//     -> 0xA5A5A5A5; 8 consecutive loads give 8 consecutive o_done pulses.
//  5. LW @0x010 accepted, i_rst = 1 on the next edge -> o_done = 0, all outputs 0;
//     a later LW @0x010 -> 0xDEAD7FEF (RAM retained).
//  6. funct3 = 3'b111 load, and SB with funct3 = 3'b100 -> o_err = 1, no RAM change;
//     o_err_sticky stays 1 until i_rst.

Source files
------------

// File: rtl/data_memory_lsu.sv
// Byte-addressed RV32I data memory: sized sign/zero-extending loads, byte-enabled
// stores, one request per cycle with a registered done/err/data response.
module data_memory_lsu #(
    parameter int ADDR_W   = 12,
    parameter bit ZERO_ERR = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_wrenb,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_Address,
    input  logic [31:0]       i_Datawrite,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_Dataread,
    output logic              o_err_sticky
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-3:0] idx_p0;
    logic [1:0]        lane_p0;
    logic              illegal_p0;
    logic              misalign_p0;
    logic              err_p0;
    logic              vld_p0;
    logic [3:0]        be_p0;
    logic [31:0]       wdata_p0;
    logic [31:0]       rword_p0;
    logic [31:0]       load_p0;

    // Lane select plus extension; funct3[2] marks the unsigned variants.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = word[8*lane +: 8];
        h16 = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b8[7]}}, b8};
            3'b001:  return {{16{h16[15]}}, h16};
            3'b100:  return {24'b0, b8};
            3'b101:  return {16'b0, h16};
            default: return word;
        endcase
    endfunction

    assign idx_p0  = i_Address[ADDR_W-1:2];
    assign lane_p0 = i_Address[1:0];
    assign vld_p0  = i_req && !i_rst;

    // 011/110/111 never exist; unsigned sizes have no store form.
    assign illegal_p0  = (i_funct3 == 3'b011) || (i_funct3[2] && i_funct3[1])
                      || (i_wrenb && i_funct3[2]);
    assign misalign_p0 = ((i_funct3[1:0] == 2'b01) && lane_p0[0])
                      || ((i_funct3[1:0] == 2'b10) && (lane_p0 != 2'b00));
    assign err_p0      = illegal_p0 || misalign_p0;

    always_comb begin
        be_p0    = 4'b0000;
        wdata_p0 = i_Datawrite;
        case (i_funct3[1:0])
            2'b00: begin
                be_p0    = 4'b0001 << lane_p0;
                wdata_p0 = {4{i_Datawrite[7:0]}};
            end
            2'b01: begin
                be_p0    = lane_p0[1] ? 4'b1100 : 4'b0011;
                wdata_p0 = {2{i_Datawrite[15:0]}};
            end
            2'b10:   be_p0 = 4'b1111;
            default: be_p0 = 4'b0000;
        endcase
    end

    assign rword_p0 = mem[idx_p0];
    assign load_p0  = extend_load(rword_p0, lane_p0, i_funct3);

    // Stage boundary: RAM write and response registers commit at the accepting edge.
    always_ff @(posedge i_clk) begin
        if (vld_p0 && i_wrenb && !err_p0) begin
            for (int k = 0; k < 4; k++) begin
                if (be_p0[k]) mem[idx_p0][8*k +: 8] <= wdata_p0[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_Dataread   <= 32'b0;
            o_err_sticky <= 1'b0;
        end else begin
            o_done <= i_req;
            o_err  <= i_req && err_p0;
            if (i_req && err_p0) begin
                o_err_sticky <= 1'b1;
                if (ZERO_ERR) o_Dataread <= 32'b0;
            end else if (i_req && !i_wrenb) begin
                o_Dataread <= load_p0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed scenarios plus randomized traffic checked
// against a byte-array reference model.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wrenb;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        done;
    logic        err;
    logic [31:0] rd;
    logic        sticky;

    always #5 clk = ~clk;

    data_memory_lsu #(.ADDR_W(12), .ZERO_ERR(1'b1)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_wrenb      (wrenb),
        .i_funct3     (f3),
        .i_Address    (addr),
        .i_Datawrite  (wd),
        .o_done       (done),
        .o_err        (err),
        .o_Dataread   (rd),
        .o_err_sticky (sticky)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mem_m [4096];
    logic [31:0] exp_rd;
    logic        exp_sticky;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_err(input bit wr, input logic [2:0] f, input logic [11:0] a);
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        if (wr && (f == 3'd4 || f == 3'd5)) return 1'b1;
        return (int'(a) % size_of(f)) != 0;
    endfunction

    // One accepted request; response checked 1 ns after the accepting edge.
    task automatic op(input bit wr, input logic [2:0] f, input logic [11:0] a,
                      input logic [31:0] d, input string tag);
        bit     e;
        int     sz;
        longint v;
        req = 1'b1; wrenb = wr; f3 = f; addr = a; wd = d;
        @(posedge clk);
        #1;
        e  = is_err(wr, f, a);
        sz = size_of(f);
        if (e) begin
            exp_sticky = 1'b1;
            exp_rd     = 32'h0;
        end else if (wr) begin
            for (int k = 0; k < sz; k++) mem_m[int'(a) + k] = d[8*k +: 8];
        end else begin
            v = 0;
            for (int k = sz - 1; k >= 0; k--) v = v * 256 + longint'(mem_m[int'(a) + k]);
            if (f[2] == 1'b0 && sz < 4 && v >= (64'sd1 << (8*sz - 1))) v = v - (64'sd1 << (8*sz));
            exp_rd = v[31:0];
        end
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".rd"}, rd, exp_rd);
        chk({tag, ".sticky"}, 32'(sticky), 32'(exp_sticky));
    endtask

    task automatic idle();
        req = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.rd", rd, exp_rd);
        chk("idle.sticky", 32'(sticky), 32'(exp_sticky));
    endtask

    // Reset with an optional competing store that must be dropped.
    task automatic do_reset(input bit with_req);
        rst = 1'b1; req = with_req; wrenb = 1'b1; f3 = 3'b010; addr = 12'h010; wd = 32'h1111_1111;
        @(posedge clk);
        #1;
        exp_rd = 32'h0;
        exp_sticky = 1'b0;
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.rd", rd, 32'h0);
        chk("rst.sticky", 32'(sticky), 32'd0);
        rst = 1'b0;
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wrenb = 1'b0; f3 = 3'b000; addr = 12'h000; wd = 32'h0;
        exp_rd = 32'h0; exp_sticky = 1'b0;
        do_reset(1'b0);
        do_reset(1'b0);

        for (int w = 0; w < 16; w++) op(1'b1, 3'b010, 12'(w * 4), 32'h0, "init");
        op(1'b1, 3'b010, 12'hFFC, 32'h0, "inithi");

        op(1'b1, 3'b010, 12'h010, 32'hDEAD_BEEF, "t1sw");
        op(1'b0, 3'b010, 12'h010, 32'h0, "t1lw");
        chk("t1.val", rd, 32'hDEAD_BEEF);

        op(1'b1, 3'b000, 12'h011, 32'h0000_007F, "t2sb");
        op(1'b0, 3'b010, 12'h010, 32'h0, "t2lw");
        chk("t2.lw", rd, 32'hDEAD_7FEF);
        op(1'b0, 3'b000, 12'h013, 32'h0, "t2lb");
        chk("t2.lb", rd, 32'hFFFF_FFDE);
        op(1'b0, 3'b100, 12'h013, 32'h0, "t2lbu");
        chk("t2.lbu", rd, 32'h0000_00DE);
        op(1'b0, 3'b001, 12'h012, 32'h0, "t2lh");
        chk("t2.lh", rd, 32'hFFFF_DEAD);
        op(1'b0, 3'b101, 12'h012, 32'h0, "t2lhu");
        chk("t2.lhu", rd, 32'h0000_DEAD);

        op(1'b1, 3'b001, 12'h011, 32'h0000_1234, "t3sh");
        chk("t3.err", 32'(err), 32'd1);
        chk("t3.sticky", 32'(sticky), 32'd1);
        op(1'b0, 3'b010, 12'h010, 32'h0, "t3lw");
        chk("t3.keep", rd, 32'hDEAD_7FEF);
        op(1'b0, 3'b010, 12'h012, 32'h0, "t3lwmis");
        chk("t3.zero", rd, 32'h0);

        op(1'b1, 3'b010, 12'h020, 32'hA5A5_A5A5, "t4sw");
        op(1'b0, 3'b010, 12'h020, 32'h0, "t4lw");
        chk("t4.val", rd, 32'hA5A5_A5A5);
        for (int i = 0; i < 8; i++) op(1'b0, 3'b000, 12'($urandom_range(0, 63)), 32'h0, "t4burst");
        idle();

        op(1'b0, 3'b010, 12'h010, 32'h0, "t5lw");
        do_reset(1'b0);
        op(1'b0, 3'b010, 12'h010, 32'h0, "t5lw2");
        chk("t5.val", rd, 32'hDEAD_7FEF);

        op(1'b0, 3'b111, 12'h010, 32'h0, "t6ill");
        op(1'b1, 3'b100, 12'h010, 32'h0000_00FF, "t6sbu");
        idle();
        op(1'b0, 3'b010, 12'h010, 32'h0, "t6lw");
        chk("t6.keep", rd, 32'hDEAD_7FEF);
        chk("t6.sticky", 32'(sticky), 32'd1);
        do_reset(1'b1);
        op(1'b0, 3'b010, 12'h010, 32'h0, "t6prio");
        chk("t6.prio", rd, 32'hDEAD_7FEF);

        op(1'b1, 3'b010, 12'hFFC, 32'hCAFE_F00D, "hisw");
        op(1'b0, 3'b001, 12'hFFE, 32'h0, "hilh");
        chk("hi.lh", rd, 32'hFFFF_CAFE);
        op(1'b0, 3'b010, 12'hFFC, 32'h0, "hilw");

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) do_reset(1'b1);
            else if (r < 3) idle();
            else op($urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)),
                    12'($urandom_range(0, 63)), $urandom, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
